// File: rtl/decoder_scan_sequencer_if.sv
// Handshake and select bundle between a scan controller and decoder_scan_sequencer.
// The master drives control and configuration, and the slave returns the decoder selects and status.
interface decoder_scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               one_shot;
    logic [7:0]         chan_mask;
    logic [DWELL_W-1:0] dwell;
    logic               sel_a;
    logic               sel_b;
    logic               sel_c;
    logic               sel_en;
    logic               chan_strobe;
    logic               frame_done;
    logic               busy;

    modport master (
        output start, stop, one_shot, chan_mask, dwell,
        input  sel_a, sel_b, sel_c, sel_en, chan_strobe, frame_done, busy
    );

    modport slave (
        input  start, stop, one_shot, chan_mask, dwell,
        output sel_a, sel_b, sel_c, sel_en, chan_strobe, frame_done, busy
    );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Round-robin scanner for a 3-to-8 decoder. Each enabled channel is blanked after its select code changes,
// then driven for a programmable dwell time. All outputs come from registers.
module decoder_scan_sequencer #(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    decoder_scan_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_t             state, state_n;
    logic [2:0]         sel, sel_n, ch;
    logic               sel_en, sel_en_n;
    logic               chan_strobe, strobe_n;
    logic               frame_done, frame_n, late_frame;
    logic               busy, go;
    logic [DWELL_W-1:0] dcnt, dcnt_n, dwell_last;
    logic [BW-1:0]      bcnt, bcnt_n;
    logic [3:0]         pick_above, pick_low, after_n;

    // Returns {found, index} for the lowest set mask bit at or above 'from'.
    function automatic logic [3:0] first_set(input logic [7:0] m, input int from);
        logic [3:0] r;
        r = 4'b0;
        for (int i = 7; i >= 0; i--)
            if (i >= from && m[i]) r = {1'b1, 3'(i)};
        return r;
    endfunction

    always_comb begin
        state_n    = state;
        sel_n      = sel;
        sel_en_n   = 1'b0;
        strobe_n   = 1'b0;
        dcnt_n     = dcnt;
        bcnt_n     = bcnt;
        go         = 1'b0;
        ch         = sel;
        late_frame = 1'b0;
        dwell_last = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
        pick_above = first_set(bus.chan_mask, int'(sel) + 1);
        pick_low   = first_set(bus.chan_mask, 0);

        if (bus.stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && pick_low[3]) begin
                        go = 1'b1;
                        ch = pick_low[2:0];
                    end
                end
                BLANK: begin
                    if (bcnt == '0) begin
                        state_n  = DRIVE;
                        sel_en_n = 1'b1;
                        strobe_n = 1'b1;
                        dcnt_n   = dwell_last;
                    end else begin
                        bcnt_n = bcnt - BW'(1);
                    end
                end
                DRIVE: begin
                    if (dcnt != '0) begin
                        sel_en_n = 1'b1;
                        dcnt_n   = dcnt - DWELL_W'(1);
                    end else if (pick_above[3]) begin
                        go = 1'b1;
                        ch = pick_above[2:0];
                    end else begin
                        // Covers a mask that changed during the final cycle, after frame_done would have been raised.
                        late_frame = !frame_done;
                        if (!bus.one_shot && pick_low[3]) begin
                            go = 1'b1;
                            ch = pick_low[2:0];
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (go) begin
            sel_n = ch;
            if (BLANK_CYC == 0) begin
                state_n  = DRIVE;
                sel_en_n = 1'b1;
                strobe_n = 1'b1;
                dcnt_n   = dwell_last;
            end else begin
                state_n = BLANK;
                bcnt_n  = BLANK_LAST;
            end
        end

        // Raise frame_done on the final drive cycle of the last channel so it coincides with that cycle.
        after_n = first_set(bus.chan_mask, int'(sel_n) + 1);
        frame_n = late_frame || (state_n == DRIVE && dcnt_n == '0 && !after_n[3]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= 3'b000;
            sel_en      <= 1'b0;
            chan_strobe <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            dcnt        <= '0;
            bcnt        <= '0;
        end else begin
            state       <= state_n;
            sel         <= sel_n;
            sel_en      <= sel_en_n;
            chan_strobe <= strobe_n;
            frame_done  <= frame_n;
            busy        <= (state_n != IDLE);
            dcnt        <= dcnt_n;
            bcnt        <= bcnt_n;
        end
    end

    assign bus.sel_a       = sel[2];
    assign bus.sel_b       = sel[1];
    assign bus.sel_c       = sel[0];
    assign bus.sel_en      = sel_en;
    assign bus.chan_strobe = chan_strobe;
    assign bus.frame_done  = frame_done;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer with BLANK_CYC = 2.
// Outputs are sampled 1 ns after each rising edge and compared as {busy, frame_done, chan_strobe, sel_en, sel[2:0]}.
module tb_decoder_scan_sequencer;
    localparam int BLANK_CYC = 2;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    decoder_scan_sequencer_if #(.DWELL_W(8)) bus ();

    decoder_scan_sequencer #(.DWELL_W(8), .BLANK_CYC(BLANK_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] expv(input logic b, input logic fd, input logic cs,
                                        input logic en, input logic [2:0] code);
        return {b, fd, cs, en, code};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] expected);
        logic [6:0] observed;
        observed = {bus.busy, bus.frame_done, bus.chan_strobe, bus.sel_en,
                    bus.sel_a, bus.sel_b, bus.sel_c};
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p);
        bus.start = s;
        bus.stop  = p;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    // Checks a full channel period, from its first blank cycle to the cycle after its last drive cycle.
    task automatic expectChannel(input string tag, input int ch, input int dw, input logic lastch);
        for (int b = 0; b < BLANK_CYC; b++) begin
            checkOutput($sformatf("%s_ch%0d_blank%0d", tag, ch, b), expv(1'b1, 1'b0, 1'b0, 1'b0, 3'(ch)));
            tick();
        end
        for (int d = 0; d < dw; d++) begin
            checkOutput($sformatf("%s_ch%0d_drive%0d", tag, ch, d),
                        expv(1'b1, lastch && (d == dw - 1), d == 0, 1'b1, 3'(ch)));
            tick();
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.one_shot  = 1'b0;
        bus.chan_mask = 8'h00;
        bus.dwell     = 8'd0;
        #12;
        checkOutput("reset", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_after_reset", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));

        // T1: full mask, continuous, two frames of 40 cycles.
        bus.chan_mask = 8'hFF;
        bus.dwell     = 8'd3;
        applyStimulus(1'b1, 1'b0);
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 8; c++)
                expectChannel($sformatf("t1_f%0d", f), c, 3, c == 7);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t1_stop", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));

        // T2: sparse mask, one-shot, dwell 1.
        bus.chan_mask = 8'b1010_0100;
        bus.one_shot  = 1'b1;
        bus.dwell     = 8'd1;
        applyStimulus(1'b1, 1'b0);
        expectChannel("t2", 2, 1, 1'b0);
        expectChannel("t2", 5, 1, 1'b0);
        expectChannel("t2", 7, 1, 1'b1);
        checkOutput("t2_idle0", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd7));
        tick();
        checkOutput("t2_idle1", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd7));

        // T3: dwell 0 behaves as 1; single channel re-driven with blanking each period.
        bus.chan_mask = 8'h01;
        bus.one_shot  = 1'b0;
        bus.dwell     = 8'd0;
        applyStimulus(1'b1, 1'b0);
        for (int r = 0; r < 3; r++)
            expectChannel($sformatf("t3_r%0d", r), 0, 1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t3_stop", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));

        // T4: stop during the second drive cycle of channel 3, then start and stop together.
        bus.chan_mask = 8'hFF;
        bus.dwell     = 8'd3;
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c < 3; c++)
            expectChannel("t4", c, 3, 1'b0);
        tick();
        tick();
        checkOutput("t4_ch3_drive0", expv(1'b1, 1'b0, 1'b1, 1'b1, 3'd3));
        tick();
        checkOutput("t4_ch3_drive1", expv(1'b1, 1'b0, 1'b0, 1'b1, 3'd3));
        applyStimulus(1'b0, 1'b1);
        checkOutput("t4_stopped", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
        tick();
        checkOutput("t4_no_frame", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
        applyStimulus(1'b1, 1'b1);
        checkOutput("t4_start_stop", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
        tick();
        checkOutput("t4_still_idle", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd3));

        // T5: asynchronous reset in the middle of a drive cycle.
        bus.chan_mask = 8'b0001_1000;
        applyStimulus(1'b1, 1'b0);
        expectChannel("t5", 3, 3, 1'b0);
        tick();
        tick();
        checkOutput("t5_ch4_drive0", expv(1'b1, 1'b0, 1'b1, 1'b1, 3'd4));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_reset", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("t5_post_reset", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        applyStimulus(1'b1, 1'b0);
        expectChannel("t5_restart", 3, 3, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t5_stop", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd4));

        // T6: start with an empty mask, then clear the mask during channel 4.
        bus.chan_mask = 8'h00;
        applyStimulus(1'b1, 1'b0);
        checkOutput("t6_empty0", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd4));
        tick();
        checkOutput("t6_empty1", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd4));
        bus.chan_mask = 8'hFF;
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c < 4; c++)
            expectChannel("t6", c, 3, 1'b0);
        tick();
        tick();
        checkOutput("t6_ch4_drive0", expv(1'b1, 1'b0, 1'b1, 1'b1, 3'd4));
        bus.chan_mask = 8'h00;
        tick();
        checkOutput("t6_ch4_drive1", expv(1'b1, 1'b0, 1'b0, 1'b1, 3'd4));
        tick();
        checkOutput("t6_ch4_drive2", expv(1'b1, 1'b1, 1'b0, 1'b1, 3'd4));
        tick();
        checkOutput("t6_idle", expv(1'b0, 1'b0, 1'b0, 1'b0, 3'd4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
